// File: rtl/mix_engine.sv
// mix_engine: mixes LANES x WIDTH words over ROUNDS rounds of a 7-stage schedule (8 with MIX_ENGINE_CUBE_STAGE_EN), one stage per clock.
// Latency NSTAGES*ROUNDS cycles accept->out_valid; result held until out_ready, no new job accepted meanwhile.
module mix_engine #(
  parameter int LANES  = 8,
  parameter int WIDTH  = 32,
  parameter int ROUNDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [15:0]            job_count
);

`ifdef MIX_ENGINE_CUBE_STAGE_EN
  localparam int NSTAGES = 8;
`else
  localparam int NSTAGES = 7;
`endif
  localparam int SW = 3;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [RW-1:0]    round_q, round_d;
  logic [15:0]      job_count_q, job_count_d;
  logic [WIDTH-1:0] lanes_q [LANES];
  logic [WIDTH-1:0] lanes_d [LANES];
  logic [WIDTH-1:0] mix     [LANES];
  logic             stage_last, round_last;

  assign stage_last = (stage_q == SW'(NSTAGES - 1));
  assign round_last = (round_q == RW'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (stage_last && round_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    job_count = job_count_q;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*WIDTH +: WIDTH] = lanes_q[i];
    end
  end

  // In-place update in lane order: lane i sees new values for j<i, old values for j>=i.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      mix[i] = lanes_q[i];
    end
    for (int i = 0; i < LANES; i++) begin
      case (stage_q)
        3'd0: mix[i] = mix[i] + WIDTH'(i);
        3'd1: mix[i] = mix[i] + mix[(i + LANES - 1) % LANES];
        3'd2: mix[i] = mix[i] + mix[(i + 1) % LANES] - mix[(i + 5) % LANES];
        3'd3: mix[i] = mix[i] ^ (mix[(i + 3) % LANES] << (WIDTH / 2));
        3'd4: mix[i] = mix[i] - (mix[(i + 2) % LANES] >> (WIDTH / 2 + 1))
                              + (mix[(i + 4) % LANES] >> (3 * WIDTH / 8));
        3'd5: mix[i] = mix[i] + mix[(i + LANES - 1) % LANES] - mix[(i + 2 * LANES - 2) % LANES];
        3'd6: mix[i] = mix[i] * WIDTH'(2 * i + 3) + WIDTH'(4 * i + 1);
`ifdef MIX_ENGINE_CUBE_STAGE_EN
        3'd7: mix[i] = mix[i] * WIDTH'(3) + WIDTH'(i * i * i);
`endif
        default: mix[i] = mix[i];
      endcase
    end
  end

  always_comb begin
    stage_d     = stage_q;
    round_d     = round_q;
    job_count_d = job_count_q;
    for (int i = 0; i < LANES; i++) begin
      lanes_d[i] = lanes_q[i];
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            lanes_d[i] = in_data[i*WIDTH +: WIDTH];
          end
          stage_d = '0;
          round_d = '0;
        end
      end
      RUN: begin
        for (int i = 0; i < LANES; i++) begin
          lanes_d[i] = mix[i];
        end
        stage_d = stage_last ? '0 : stage_q + SW'(1);
        if (stage_last) begin
          round_d = round_last ? '0 : round_q + RW'(1);
        end
      end
      DONE: begin
        if (out_ready) job_count_d = job_count_q + 16'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      round_q     <= '0;
      job_count_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else begin
      stage_q     <= stage_d;
      round_q     <= round_d;
      job_count_q <= job_count_d;
      for (int i = 0; i < LANES; i++) begin
        lanes_q[i] <= lanes_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mix_engine.sv
// Directed bench for mix_engine: a default instance (8x32, 4 rounds) and a small one (2x32, 1 round) on a shared clock/reset.
module tb_mix_engine;

`ifdef MIX_ENGINE_CUBE_STAGE_EN
  localparam int NST = 8;
`else
  localparam int NST = 7;
`endif

  logic         clk, rst;
  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [255:0] b_in_data, b_out_data;
  logic [15:0]  b_job_count;
  logic         s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [63:0]  s_in_data, s_out_data;
  logic [15:0]  s_job_count;

  int errors = 0;
  int n_checks = 0;

  mix_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .job_count(b_job_count)
  );

  mix_engine #(.LANES(2), .WIDTH(32), .ROUNDS(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .job_count(s_job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: n lanes of 32 bits, straight from the stage equations.
  function automatic logic [255:0] model(input logic [255:0] din, input int n, input int rounds);
    logic [31:0]  o [8];
    logic [255:0] res;
    for (int i = 0; i < n; i++) o[i] = din[i*32 +: 32];
    for (int r = 0; r < rounds; r++) begin
      for (int s = 0; s < NST; s++) begin
        for (int i = 0; i < n; i++) begin
          case (s)
            0: o[i] = o[i] + 32'(i);
            1: o[i] = o[i] + o[(i + n - 1) % n];
            2: o[i] = o[i] + o[(i + 1) % n] - o[(i + 5) % n];
            3: o[i] = o[i] ^ (o[(i + 3) % n] << 16);
            4: o[i] = o[i] - (o[(i + 2) % n] >> 17) + (o[(i + 4) % n] >> 12);
            5: o[i] = o[i] + o[(i + n - 1) % n] - o[(i + 2 * n - 2) % n];
            6: o[i] = o[i] * 32'(2 * i + 3) + 32'(4 * i + 1);
            default: o[i] = o[i] * 32'd3 + 32'(i * i * i);
          endcase
        end
      end
    end
    res = '0;
    for (int i = 0; i < n; i++) res[i*32 +: 32] = o[i];
    return res;
  endfunction

  task automatic run_small(input logic [63:0] din, output int lat, output logic [63:0] res);
    @(posedge clk); #1;
    s_in_data  = din;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = s_out_data;
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
  endtask

  // Leaves the big engine in DONE; the caller releases it.
  task automatic run_big(input logic [255:0] din, output int lat);
    @(posedge clk); #1;
    b_in_data  = din;
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  typedef struct {
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t         vecs [4];
  logic [255:0] pat  [6];
  logic [255:0] res_hold;
  logic [63:0]  s_res;
  int           lat, bad, done_n, acc_n;
  int           acc_cyc [3];
  logic         acc, fin;

  initial begin
`ifdef MIX_ENGINE_CUBE_STAGE_EN
    vecs[0].din = 64'h0;                    vecs[0].exp = {32'h000F011E, 32'h000900A5};
    vecs[1].din = {32'h0, 32'hFFFFFFFF};    vecs[1].exp = {32'h0000001F, 32'h0000000C};
`else
    vecs[0].din = 64'h0;                    vecs[0].exp = {32'h0005005F, 32'h00030037};
    vecs[1].din = {32'h0, 32'hFFFFFFFF};    vecs[1].exp = {32'h0000000A, 32'h00000004};
`endif
    vecs[2].din = 64'h12345678_9ABCDEF0;
    vecs[2].exp = model({192'h0, vecs[2].din}, 2, 1);
    vecs[3].din = 64'hDEADBEEF_00000001;
    vecs[3].exp = model({192'h0, vecs[3].din}, 2, 1);

    pat[0] = {32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
    pat[1] = {8{32'hFFFFFFFF}};
    pat[2] = {8{32'hA5A55A5A}};
    pat[3] = 256'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEFCAFEF00D_0000000180000000;
    pat[4] = {32'h80000000, 192'h0, 32'h1};
    pat[5] = {4{64'h00010002_FFFF0000}};

    rst = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",    256'(b_in_ready),  256'd1);
    check("rst_out_valid",   256'(b_out_valid), 256'd0);
    check("rst_job_count",   256'(b_job_count), 256'd0);
    check("rst_out_data",    b_out_data,        256'd0);
    check("rst_s_in_ready",  256'(s_in_ready),  256'd1);
    check("rst_s_out_data",  256'(s_out_data),  256'd0);
    rst = 1'b0;

    // Small-job table
    for (int k = 0; k < 4; k++) begin
      run_small(vecs[k].din, lat, s_res);
      check($sformatf("small%0d_latency", k), 256'(lat),   256'(NST));
      check($sformatf("small%0d_data", k),    256'(s_res), 256'(vecs[k].exp));
    end
    check("small_job_count", 256'(s_job_count), 256'd4);

    // Default latency and backpressure; in_valid held high in DONE must be ignored
    run_big(pat[0], lat);
    check("bp_latency", 256'(lat), 256'(NST * 4));
    res_hold = b_out_data;
    check("bp_data", res_hold, model(pat[0], 8, 4));
    b_in_data  = pat[1];
    b_in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (b_out_data !== res_hold || b_in_ready !== 1'b0 || b_out_valid !== 1'b1) bad++;
    end
    check("bp_hold_stable", 256'(bad), 256'd0);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    b_in_valid  = 1'b0;
    check("bp_job_count", 256'(b_job_count), 256'd1);
    check("bp_in_ready",  256'(b_in_ready),  256'd1);
    check("bp_out_valid", 256'(b_out_valid), 256'd0);

    // Abort at cycle 12 of a job
    b_in_data  = pat[2];
    b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
    end
    check("abort_running", 256'({b_in_ready, b_out_valid}), 256'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  256'(b_in_ready),  256'd1);
    check("abort_out_valid", 256'(b_out_valid), 256'd0);
    check("abort_job_count", 256'(b_job_count), 256'd0);
    check("abort_out_data",  b_out_data,        256'd0);
    run_big(pat[3], lat);
    check("after_abort_latency", 256'(lat), 256'(NST * 4));
    check("after_abort_data", b_out_data, model(pat[3], 8, 4));
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    check("after_abort_job_count", 256'(b_job_count), 256'd1);

    // Back-to-back with in_valid and out_ready held high
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_n = 0;
    acc_n  = 0;
    b_in_data   = pat[4];
    b_in_valid  = 1'b1;
    b_out_ready = 1'b1;
    for (int c = 0; c < 400 && done_n < 3; c++) begin
      acc = b_in_ready && (acc_n < 3);
      fin = b_out_valid;
      if (fin) begin
        check($sformatf("b2b%0d_data", done_n), b_out_data, model(pat[4 + done_n], 8, 4));
        done_n++;
      end
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[acc_n] = c;
        acc_n++;
        if (acc_n < 3) b_in_data = pat[4 + acc_n];
        else b_in_valid = 1'b0;
      end
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    check("b2b_jobs_done", 256'(done_n), 256'd3);
    check("b2b_job_count", 256'(b_job_count), 256'd3);
    if (acc_n == 3) begin
      check("b2b_spacing1", 256'(acc_cyc[1] - acc_cyc[0]), 256'(NST * 4 + 2));
      check("b2b_spacing2", 256'(acc_cyc[2] - acc_cyc[1]), 256'(NST * 4 + 2));
    end else begin
      check("b2b_accepts", 256'(acc_n), 256'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
